main_mem_ctrl: RTL and testbench

- Main-memory model and controller directly downstream of the 2-way write-through data cache.
- Serves the cache's two request lines on the cache/memory interface:
  - single-word write-through (memwritethru)
  - 4-word block fetch on miss (readmiss), returned as one 128-bit block
- Models a fixed first-access latency plus a one-word-per-cycle burst.
- Pulses writeready/readready to hand completion back to the cache.

---
 rtl/main_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_main_mem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// Main-memory model behind the write-through data cache: fixed first-access
// latency, single-word write-through and 4-beat block fetch with ready pulses.
module main_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 20
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [31:0]  address,
    input  logic [31:0]  datawrite,
    input  logic         memwritethru,
    input  logic         readmiss,
    output logic [127:0] datareadmiss,
    output logic         readready,
    output logic         writeready,
    output logic         busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_beat;
    logic [1:0]         w_beat_nxt;
    logic [IDX_W-1:0]   r_widx;
    logic [31:0]        r_wdata;
    logic               r_do_read;
    logic [127:0]       r_stage;
    logic [127:0]       w_stage_nxt;
    logic [127:0]       r_dout;
    logic               r_rready;
    logic               r_wready;
    logic               r_busy;
    logic               w_accept;
    logic               w_mem_we;
    logic               w_stage_we;
    logic               w_wready_nxt;
    logic               w_rready_nxt;
    logic               w_busy_nxt;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [31:0]        w_rd_word;
    logic               w_unused;

    logic [31:0]        r_mem [MEM_WORDS];

    // The block base is the upper part of the latched word index, so blocks stay aligned.
    assign w_rd_idx  = {r_widx[IDX_W-1:2], r_beat};
    assign w_rd_word = r_mem[w_rd_idx];
    assign w_unused  = ^{address[31:IDX_W+2], address[1:0]};

    assign datareadmiss = r_dout;
    assign readready    = r_rready;
    assign writeready   = r_wready;
    assign busy         = r_busy;

    // Merge the current beat's word into the staging block.
    always_comb begin
        w_stage_nxt = r_stage;
        case (r_beat)
            2'd0:    w_stage_nxt[31:0]   = w_rd_word;
            2'd1:    w_stage_nxt[63:32]  = w_rd_word;
            2'd2:    w_stage_nxt[95:64]  = w_rd_word;
            2'd3:    w_stage_nxt[127:96] = w_rd_word;
            default: w_stage_nxt = r_stage;
        endcase
    end

    // Next-state, counter and completion decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_beat_nxt   = r_beat;
        w_accept     = 1'b0;
        w_mem_we     = 1'b0;
        w_stage_we   = 1'b0;
        w_wready_nxt = 1'b0;
        w_rready_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memwritethru || readmiss) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = memwritethru ? ST_WR_WAIT : ST_RD_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_mem_we     = 1'b1;
                    w_wready_nxt = 1'b1;
                    // A write miss commits first, then fetches the (now updated) block.
                    if (r_do_read) begin
                        w_state_nxt = ST_RD_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ST_COOLDOWN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_RD_BURST;
                    w_beat_nxt  = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_RD_BURST: begin
                w_stage_we = 1'b1;
                if (r_beat == 2'd3) begin
                    w_rready_nxt = 1'b1;
                    w_state_nxt  = ST_COOLDOWN;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                end
            end
            ST_COOLDOWN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counter and beat registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Request latch, staging block and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_widx    <= {IDX_W{1'b0}};
            r_wdata   <= 32'h0;
            r_do_read <= 1'b0;
            r_stage   <= 128'h0;
            r_dout    <= 128'h0;
            r_rready  <= 1'b0;
            r_wready  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_widx    <= address[IDX_W+1:2];
                r_wdata   <= datawrite;
                r_do_read <= readmiss;
            end
            if (w_stage_we) begin
                r_stage <= w_stage_nxt;
            end
            if (w_rready_nxt) begin
                r_dout <= w_stage_nxt;
            end
            r_rready <= w_rready_nxt;
            r_wready <= w_wready_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[r_widx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomized scoreboard bench for main_mem_ctrl: a word-array reference model
// predicts each ready pulse (kind, edge number, block) and a monitor checks it.
module tb_main_mem_ctrl;

    localparam int LAT = 20;
    localparam int MW  = 1024;

    typedef struct {
        bit           is_read;
        logic [127:0] data;
        int           due;
    } exp_t;

    logic         Clk          = 1'b0;
    logic         Rst          = 1'b0;
    logic [31:0]  address      = 32'h0;
    logic [31:0]  datawrite    = 32'h0;
    logic         memwritethru = 1'b0;
    logic         readmiss     = 1'b0;
    logic [127:0] datareadmiss;
    logic         readready;
    logic         writeready;
    logic         busy;

    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    logic [31:0]  ref_mem [MW];
    logic [127:0] last_blk = 128'h0;
    int           blks[6] = '{0, 1, 16, 32, 48, 255};

    main_mem_ctrl #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .address      (address),
        .datawrite    (datawrite),
        .memwritethru (memwritethru),
        .readmiss     (readmiss),
        .datareadmiss (datareadmiss),
        .readready    (readready),
        .writeready   (writeready),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [127:0] ref_block(input int b);
        return {ref_mem[b*4+3], ref_mem[b*4+2], ref_mem[b*4+1], ref_mem[b*4]};
    endfunction

    // Returns #1 after edge number e (immediately if already there).
    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic run_txn(input bit w, input bit r, input logic [31:0] addr,
                           input logic [31:0] data, input bit hold, input bit scramble);
        int   e0;
        int   fin;
        int   widx;
        int   bidx;
        exp_t e;
        widx         = int'(addr[11:2]);
        bidx         = int'(addr[11:4]);
        address      = addr;
        datawrite    = data;
        memwritethru = w;
        readmiss     = r;
        e0           = cyc + 1;
        fin          = e0 + LAT;
        if (w) begin
            e.is_read = 1'b0;
            e.data    = {96'h0, data};
            e.due     = e0 + LAT;
            exp_q.push_back(e);
            ref_mem[widx] = data;
        end
        if (r) begin
            fin       = w ? (e0 + 2*LAT + 4) : (e0 + LAT + 4);
            e.is_read = 1'b1;
            e.data    = ref_block(bidx);
            e.due     = fin;
            exp_q.push_back(e);
        end
        wait_until(e0);
        check("busy_after_accept", 128'(busy), 128'd1);
        if (scramble) begin
            wait_until(e0 + 2);
            address   = $urandom;
            datawrite = $urandom;
            if (!w) memwritethru = 1'($urandom_range(0, 1));
            if (!r) readmiss     = 1'($urandom_range(0, 1));
        end
        wait_until(fin + (hold ? 1 : 0));
        memwritethru = 1'b0;
        readmiss     = 1'b0;
        wait_until(fin + 1);
        check("busy_after_cooldown", 128'(busy), 128'd0);
        check("pending_responses", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        wait_until(fin + 1 + $urandom_range(0, 2));
    endtask

    task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
        int e0;
        address      = addr;
        datawrite    = data;
        memwritethru = 1'b1;
        readmiss     = 1'b0;
        e0           = cyc + 1;
        wait_until(e0 + 10);
        #1 Rst = 1'b0;
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_writeready", 128'(writeready), 128'd0);
        check("rst_readready", 128'(readready), 128'd0);
        check("rst_datareadmiss", datareadmiss, 128'h0);
        memwritethru = 1'b0;
        wait_until(cyc + 2);
        Rst = 1'b1;
        wait_until(cyc + 1);
    endtask

    // Monitor: every ready pulse must match the oldest prediction.
    initial begin
        exp_t mon_e;
        forever begin
            @(posedge Clk);
            #1;
            if (!Rst) last_blk = 128'h0;
            if (writeready || readready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready at edge %0d: writeready=%b readready=%b, required no pulse",
                             cyc, writeready, readready);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready_kind", 128'({writeready, readready}), mon_e.is_read ? 128'd1 : 128'd2);
                    check("ready_edge", 128'(cyc), 128'(mon_e.due));
                    if (mon_e.is_read) begin
                        check("read_block", datareadmiss, mon_e.data);
                        last_blk = mon_e.data;
                    end
                end
            end
            check("dout_hold", datareadmiss, last_blk);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int          kind;
        wait_until(3);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_writeready", 128'(writeready), 128'd0);
        check("reset_readready", 128'(readready), 128'd0);
        check("reset_datareadmiss", datareadmiss, 128'h0);
        Rst = 1'b1;
        wait_until(cyc + 1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (blks[i] == 16)      d = 32'h11 * (k + 1);
                else if (blks[i] == 48) d = k + 1;
                else                    d = $urandom;
                run_txn(1'b1, 1'b0, 32'(blks[i] * 16 + k * 4), d, 1'b0, 1'b0);
            end
        end

        run_txn(1'b0, 1'b1, 32'h104, 32'h0, 1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 32'h208, 32'hDEADBEEF, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h30C, 32'hCAFEF00D, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
        abort_write(32'h10, 32'h5555AAAA);
        run_txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h1000, 32'h0, 1'b1, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'hFF8, 32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            a    = ($urandom & 32'hFFFF_F000) | 32'(blks[$urandom_range(0, 5)] * 16)
                   | 32'($urandom_range(0, 15));
            run_txn(kind != 1, kind != 0, a, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        wait_until(cyc + 5);
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
